// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit: instruction fetch stage ahead of decode.
// Owns the fetch PC and issues requests to the instruction cache, one
// outstanding at a time. Returned words go into a DEPTH-entry prefetch queue,
// and the queue head is presented to decode.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN. When it is defined, a
// redirect to a misaligned target halts fetch and sets misalign_err. When it
// is undefined, the low two bits of jump_target are ignored.
module fetch_queue_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        data_hazard,
    input  logic        jump_taken,
    input  logic [31:0] jump_target,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_ack,
    input  logic [31:0] ic_data,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    output logic        icache_stall,
    output logic        misalign_err
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

    state_t             state;
    logic [31:0]        fetch_pc;
    logic [31:0]        q_instr [DEPTH];
    logic [31:0]        q_pc    [DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;

    logic               advance;
    logic               push;
    logic               pop;
    logic               space;
    logic               halted;
    logic               misaligned;
    logic [31:0]        target;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic               err_q;

    assign misaligned   = jump_target[1:0] != 2'b00;
    assign target       = jump_target;
    assign misalign_err = err_q;

    // A misaligned redirect halts fetch; the next aligned redirect resumes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halted <= 1'b0;
            err_q  <= 1'b0;
        end else if (jump_taken) begin
            halted <= misaligned;
            err_q  <= misaligned;
        end
    end
`else
    logic               jt_low_unused;

    assign jt_low_unused = ^jump_target[1:0];
    assign misaligned    = 1'b0;
    assign target        = {jump_target[31:2], 2'b00};
    assign halted        = 1'b0;
    assign misalign_err  = 1'b0;
`endif

    assign advance      = instr_valid & ~stall & ~data_hazard;
    assign push         = (state == REQ) & ic_ack & ~jump_taken;
    assign pop          = advance & ~jump_taken;
    assign space        = count < CNT_W'(DEPTH);

    assign instr_valid  = count != '0;
    assign icache_stall = count == '0;
    assign instr        = instr_valid ? q_instr[rd_ptr] : '0;
    assign instr_pc     = instr_valid ? q_pc[rd_ptr]    : '0;

    // Request FSM: issue a request, wait for ack, and drop the response when a redirect raced it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
            ic_req   <= 1'b0;
            ic_addr  <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (jump_taken) begin
                        fetch_pc <= target;
                    end else if (space && !halted) begin
                        ic_req  <= 1'b1;
                        ic_addr <= fetch_pc;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    if (ic_ack) begin
                        ic_req   <= 1'b0;
                        state    <= IDLE;
                        fetch_pc <= jump_taken ? target : fetch_pc + 32'd4;
                    end else if (jump_taken) begin
                        // The request stays up at the old address; its data is discarded on arrival.
                        fetch_pc <= target;
                        state    <= DISCARD;
                    end
                end
                DISCARD: begin
                    if (jump_taken) begin
                        fetch_pc <= target;
                    end
                    if (ic_ack) begin
                        ic_req <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state  <= IDLE;
                    ic_req <= 1'b0;
                end
            endcase
        end
    end

    // Queue pointers and occupancy; a redirect flushes even when the head is being popped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (jump_taken) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Queue storage: write the returned word together with the PC it was fetched from.
    always_ff @(posedge clk) begin
        if (push) begin
            q_instr[wr_ptr] <= ic_data;
            q_pc[wr_ptr]    <= fetch_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed testbench for fetch_queue_unit (DEPTH=4, RESET_PC=0).
module tb_fetch_queue_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        data_hazard;
    logic        jump_taken;
    logic [31:0] jump_target;
    logic        ic_req;
    logic [31:0] ic_addr;
    logic        ic_ack;
    logic [31:0] ic_data;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        icache_stall;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    fetch_queue_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .data_hazard  (data_hazard),
        .jump_taken   (jump_taken),
        .jump_target  (jump_target),
        .ic_req       (ic_req),
        .ic_addr      (ic_addr),
        .ic_ack       (ic_ack),
        .ic_data      (ic_data),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .instr_valid  (instr_valid),
        .icache_stall (icache_stall),
        .misalign_err (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        stall       = 1'b0;
        data_hazard = 1'b0;
        jump_taken  = 1'b0;
        jump_target = '0;
        ic_ack      = 1'b0;
        ic_data     = '0;
        tick();
        rst = 1'b0;
    endtask

    // Waits up to 20 cycles for ic_req and reports the address it carries.
    task automatic wait_req(output bit ok, output logic [31:0] addr);
        ok   = 1'b0;
        addr = '0;
        for (int n = 0; n < 20; n++) begin
            if (ic_req === 1'b1) begin
                ok   = 1'b1;
                addr = ic_addr;
                break;
            end
            tick();
        end
    endtask

    task automatic ack_word(input logic [31:0] data);
        ic_ack  = 1'b1;
        ic_data = data;
        tick();
        ic_ack  = 1'b0;
        ic_data = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; stall = 1'b0; data_hazard = 1'b0; jump_taken = 1'b0;
        jump_target = '0; ic_ack = 1'b0; ic_data = '0;
        #1;
        checks++;
        if (ic_req !== 1'b0 || ic_addr !== 32'h0 || instr !== 32'h0 || instr_pc !== 32'h0 ||
            instr_valid !== 1'b0 || icache_stall !== 1'b1 || misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got req=%b addr=%h instr=%h pc=%h v=%b ics=%b mis=%b exp 0,0,0,0,0,1,0",
                     ic_req, ic_addr, instr, instr_pc, instr_valid, icache_stall, misalign_err);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        checks++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h0) begin
            errors++;
            $display("FAIL reset_first_req got req=%b addr=%h exp 1 00000000", ic_req, ic_addr);
        end
    endtask

    task automatic test_sequential();
        bit ok;
        logic [31:0] a;
        logic [31:0] exp_pc;
        logic [31:0] exp_d;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_pc = 32'(i * 4);
            exp_d  = 32'hA000_0000 + 32'(i);
            wait_req(ok, a);
            checks++;
            if (!ok || a !== exp_pc) begin
                errors++;
                $display("FAIL seq_addr[%0d] got ok=%b addr=%h exp %h", i, ok, a, exp_pc);
            end
            ack_word(exp_d);
            checks++;
            if (instr_valid !== 1'b1 || instr !== exp_d || instr_pc !== exp_pc || icache_stall !== 1'b0) begin
                errors++;
                $display("FAIL seq_head[%0d] got v=%b instr=%h pc=%h ics=%b exp 1 %h %h 0",
                         i, instr_valid, instr, instr_pc, icache_stall, exp_d, exp_pc);
            end
        end
    endtask

    task automatic test_stall_fill();
        bit ok;
        bit seen_req;
        logic [31:0] a;
        do_reset();
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_req(ok, a);
            checks++;
            if (!ok || a !== 32'(i * 4)) begin
                errors++;
                $display("FAIL fill_addr[%0d] got ok=%b addr=%h exp %h", i, ok, a, 32'(i * 4));
            end
            ack_word(32'hB000_0000 + 32'(i));
        end
        seen_req = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            if (ic_req !== 1'b0) seen_req = 1'b1;
        end
        checks++;
        if (seen_req) begin
            errors++;
            $display("FAIL fill_full_noreq got ic_req seen=1 exp 0");
        end
        checks++;
        if (icache_stall !== 1'b0 || instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'hB000_0000) begin
            errors++;
            $display("FAIL fill_head got ics=%b v=%b pc=%h instr=%h exp 0 1 00000000 b0000000",
                     icache_stall, instr_valid, instr_pc, instr);
        end
        data_hazard = 1'b1;
        stall = 1'b0;
        tick();
        checks++;
        if (instr_pc !== 32'h0) begin
            errors++;
            $display("FAIL hazard_hold got pc=%h exp 00000000", instr_pc);
        end
        data_hazard = 1'b0;
        tick();
        checks++;
        if (instr_pc !== 32'h4 || instr !== 32'hB000_0001) begin
            errors++;
            $display("FAIL release_pop got pc=%h instr=%h exp 00000004 b0000001", instr_pc, instr);
        end
        tick();
        checks++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h10 || instr_pc !== 32'h8) begin
            errors++;
            $display("FAIL refill_req got req=%b addr=%h pc=%h exp 1 00000010 00000008", ic_req, ic_addr, instr_pc);
        end
    endtask

    task automatic test_jump_outstanding();
        bit ok;
        bit bad;
        logic [31:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wait_req(ok, a);
            stall = (i >= 2);
            ack_word(32'hC000_0000 + 32'(i));
        end
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 32'h10 || instr_pc !== 32'h8 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL jo_pre got ok=%b addr=%h pc=%h v=%b exp 1 00000010 00000008 1", ok, a, instr_pc, instr_valid);
        end
        jump_taken  = 1'b1;
        jump_target = 32'h200;
        tick();
        jump_taken  = 1'b0;
        checks++;
        if (instr_valid !== 1'b0 || icache_stall !== 1'b1 || ic_req !== 1'b1 || ic_addr !== 32'h10) begin
            errors++;
            $display("FAIL jo_flush got v=%b ics=%b req=%b addr=%h exp 0 1 1 00000010",
                     instr_valid, icache_stall, ic_req, ic_addr);
        end
        bad = 1'b0;
        for (int n = 0; n < 2; n++) begin
            tick();
            if (ic_req !== 1'b1 || ic_addr !== 32'h10 || instr_valid !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            errors++;
            $display("FAIL jo_hold got req=%b addr=%h v=%b exp 1 00000010 0", ic_req, ic_addr, instr_valid);
        end
        ack_word(32'hDEAD_BEEF);
        checks++;
        if (ic_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jo_drop got req=%b v=%b exp 0 0", ic_req, instr_valid);
        end
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 32'h200) begin
            errors++;
            $display("FAIL jo_redirect_addr got ok=%b addr=%h exp 00000200", ok, a);
        end
        ack_word(32'hC0DE_0001);
        checks++;
        if (instr_valid !== 1'b1 || instr !== 32'hC0DE_0001 || instr_pc !== 32'h200) begin
            errors++;
            $display("FAIL jo_new_head got v=%b instr=%h pc=%h exp 1 c0de0001 00000200", instr_valid, instr, instr_pc);
        end
        stall = 1'b0;
    endtask

    task automatic test_jump_with_ack();
        bit ok;
        logic [31:0] a;
        do_reset();
        wait_req(ok, a);
        ack_word(32'h1111_0000);
        wait_req(ok, a);
        ic_ack      = 1'b1;
        ic_data     = 32'h0BAD_0BAD;
        jump_taken  = 1'b1;
        jump_target = 32'h80;
        tick();
        ic_ack = 1'b0; jump_taken = 1'b0;
        checks++;
        if (ic_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jack_nopush got req=%b v=%b exp 0 0", ic_req, instr_valid);
        end
        tick();
        checks++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h80) begin
            errors++;
            $display("FAIL jack_next got req=%b addr=%h exp 1 00000080", ic_req, ic_addr);
        end
    endtask

    task automatic test_jump_idle();
        bit ok;
        logic [31:0] a;
        do_reset();
        wait_req(ok, a);
        ack_word(32'h2222_0000);
        jump_taken  = 1'b1;
        jump_target = 32'h300;
        tick();
        jump_taken  = 1'b0;
        checks++;
        if (ic_req !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL jidle_flush got req=%b v=%b exp 0 0", ic_req, instr_valid);
        end
        tick();
        checks++;
        if (ic_req !== 1'b1 || ic_addr !== 32'h300) begin
            errors++;
            $display("FAIL jidle_req got req=%b addr=%h exp 1 00000300", ic_req, ic_addr);
        end
    endtask

    task automatic test_pc_wrap();
        bit ok;
        logic [31:0] a;
        do_reset();
        wait_req(ok, a);
        ic_ack = 1'b1; ic_data = 32'h0; jump_taken = 1'b1; jump_target = 32'hFFFF_FFFC;
        tick();
        ic_ack = 1'b0; jump_taken = 1'b0;
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 32'hFFFF_FFFC) begin
            errors++;
            $display("FAIL wrap_addr0 got ok=%b addr=%h exp fffffffc", ok, a);
        end
        ack_word(32'hF1F1_F1F1);
        checks++;
        if (instr_pc !== 32'hFFFF_FFFC || instr !== 32'hF1F1_F1F1) begin
            errors++;
            $display("FAIL wrap_pc0 got pc=%h instr=%h exp fffffffc f1f1f1f1", instr_pc, instr);
        end
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr1 got ok=%b addr=%h exp 00000000", ok, a);
        end
        ack_word(32'hF2F2_F2F2);
        checks++;
        if (instr_pc !== 32'h0 || instr !== 32'hF2F2_F2F2 || instr_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pc1 got pc=%h instr=%h v=%b exp 00000000 f2f2f2f2 1", instr_pc, instr, instr_valid);
        end
    endtask

    task automatic test_misalign();
        bit ok;
        logic [31:0] a;
`ifdef FETCH_MISALIGN_CHECK_EN
        bit seen_req;
`endif
        do_reset();
        wait_req(ok, a);
        ic_ack = 1'b1; ic_data = 32'h0; jump_taken = 1'b1; jump_target = 32'h102;
        tick();
        ic_ack = 1'b0; jump_taken = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        checks++;
        if (misalign_err !== 1'b1 || ic_req !== 1'b0) begin
            errors++;
            $display("FAIL mis_set got err=%b req=%b exp 1 0", misalign_err, ic_req);
        end
        seen_req = 1'b0;
        for (int n = 0; n < 5; n++) begin
            tick();
            if (ic_req !== 1'b0) seen_req = 1'b1;
        end
        checks++;
        if (seen_req || misalign_err !== 1'b1) begin
            errors++;
            $display("FAIL mis_halt got seen_req=%b err=%b exp 0 1", seen_req, misalign_err);
        end
        jump_taken = 1'b1; jump_target = 32'h40;
        tick();
        jump_taken = 1'b0;
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL mis_clear got err=%b exp 0", misalign_err);
        end
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 32'h40) begin
            errors++;
            $display("FAIL mis_resume got ok=%b addr=%h exp 00000040", ok, a);
        end
`else
        checks++;
        if (misalign_err !== 1'b0) begin
            errors++;
            $display("FAIL mis_tied got err=%b exp 0", misalign_err);
        end
        wait_req(ok, a);
        checks++;
        if (!ok || a !== 32'h100) begin
            errors++;
            $display("FAIL mis_aligned_addr got ok=%b addr=%h exp 00000100", ok, a);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall_fill();
        test_jump_outstanding();
        test_jump_with_ack();
        test_jump_idle();
        test_pc_wrap();
        test_misalign();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
